// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer: FSM state encoding,
// full-step and half-step coil phase tables, and the de-energized drive value.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] DRIVE_OFF = 4'b0000;

  // Entry i lives at bits [4*i +: 4]; idx0 is the least significant nibble.
  localparam logic [15:0] FULL_TABLE = {4'b1100, 4'b0110, 4'b0011, 4'b1001};
  localparam logic [31:0] HALF_TABLE = {4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                        4'b0010, 4'b0011, 4'b0001, 4'b1001};

  function automatic logic [3:0] full_phase(input logic [1:0] idx);
    return FULL_TABLE[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] half_phase(input logic [2:0] idx);
    return HALF_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/stepper_seq_ctrl_step_timer.sv
// Loadable down-counter with a zero flag. Stops at zero; a load takes
// priority over counting. Used for both the step period and the hold time.
module step_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load or count down towards zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Stepper motor phase sequencer: accepts move commands, issues coil phases at
// the programmed rate, holds the coils energized for HOLD_CYCLES after a move,
// then de-energizes them. Tracks a wrapping signed position.
// Optional build macro STEPPER_HALFSTEP_EN adds cmd_half and the 8-entry
// half-step table; without it only the 4-entry full-step table exists.
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int PERIOD_W    = 24,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stepper_en,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
`ifdef STEPPER_HALFSTEP_EN
  input  logic                cmd_half,
`endif
  input  logic                abort,
  output logic [3:0]          step_drive,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  pos_count
);

`ifdef STEPPER_HALFSTEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [COUNT_W-1:0]   pos_reg, pos_next;
  logic [COUNT_W-1:0]   rem_reg, rem_next;
  logic [PERIOD_W-1:0]  period_reg, period_next;
  logic                 dir_reg, dir_next;
  logic [3:0]           drive_reg, drive_next;
  logic                 ready_reg, ready_next;
  logic                 done_reg, done_next;
  logic                 aborted_reg, aborted_next;
`ifdef STEPPER_HALFSTEP_EN
  logic                 half_reg, half_next;
  logic [IDX_W-1:0]     idx_amt;
`endif

  logic                 accept;
  logic                 step_load;
  logic [PERIOD_W-1:0]  step_load_val;
  logic                 step_zero;
  logic                 hold_load;
  logic                 hold_zero;

  step_timer #(.W(PERIOD_W)) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .load_val (step_load_val),
    .zero     (step_zero)
  );

  step_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .zero     (hold_zero)
  );

  // Next-state, step issue, position tracking and registered-output values.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pos_next      = pos_reg;
    rem_next      = rem_reg;
    period_next   = period_reg;
    dir_next      = dir_reg;
    done_next     = 1'b0;
    aborted_next  = 1'b0;
    step_load     = 1'b0;
    step_load_val = '0;
    hold_load     = 1'b0;
`ifdef STEPPER_HALFSTEP_EN
    half_next     = half_reg;
    // Full mode from an odd entry first moves by one to realign.
    idx_amt       = (half_reg || idx_reg[0]) ? IDX_W'(1) : IDX_W'(2);
`endif
    accept = cmd_valid & ready_reg & stepper_en & (state_reg != STEP);

    if (!stepper_en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (accept) begin
            dir_next    = cmd_dir;
            rem_next    = cmd_steps;
            period_next = (cmd_period == '0) ? '0 : cmd_period - PERIOD_W'(1);
`ifdef STEPPER_HALFSTEP_EN
            half_next   = cmd_half;
`endif
            // Timer loaded with zero so the first boundary falls on the next
            // cycle; a zero-step move ends there with done and no step.
            state_next    = STEP;
            step_load     = 1'b1;
            step_load_val = '0;
          end else if (state_reg == HOLD && hold_zero) begin
            state_next = IDLE;
          end
        end
        STEP: begin
          if (step_zero) begin
            if (rem_reg == '0 || abort) begin
              done_next    = 1'b1;
              aborted_next = (rem_reg != '0);
              state_next   = HOLD;
              hold_load    = 1'b1;
            end else begin
`ifdef STEPPER_HALFSTEP_EN
              idx_next = dir_reg ? idx_reg + idx_amt : idx_reg - idx_amt;
`else
              idx_next = dir_reg ? idx_reg + IDX_W'(1) : idx_reg - IDX_W'(1);
`endif
              pos_next      = dir_reg ? pos_reg + COUNT_W'(1) : pos_reg - COUNT_W'(1);
              rem_next      = rem_reg - COUNT_W'(1);
              step_load     = 1'b1;
              step_load_val = period_reg;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (state_next == IDLE) begin
      drive_next = DRIVE_OFF;
    end else begin
`ifdef STEPPER_HALFSTEP_EN
      drive_next = half_phase(idx_next);
`else
      drive_next = full_phase(idx_next);
`endif
    end
    ready_next = stepper_en & (state_next != STEP) & ~abort;
  end

  // State and output registers; async reset de-energizes the coils at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pos_reg     <= '0;
      rem_reg     <= '0;
      period_reg  <= '0;
      dir_reg     <= 1'b0;
      drive_reg   <= DRIVE_OFF;
      ready_reg   <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
`ifdef STEPPER_HALFSTEP_EN
      half_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pos_reg     <= pos_next;
      rem_reg     <= rem_next;
      period_reg  <= period_next;
      dir_reg     <= dir_next;
      drive_reg   <= drive_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
`ifdef STEPPER_HALFSTEP_EN
      half_reg    <= half_next;
`endif
    end
  end

  assign cmd_ready  = ready_reg;
  assign step_drive = drive_reg;
  assign busy       = (state_reg == STEP);
  assign done       = done_reg;
  assign aborted    = aborted_reg;
  assign pos_count  = pos_reg;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Self-checking bench for stepper_seq_ctrl (HOLD_CYCLES overridden to 20).
// A cycle-level behavioural model derives step times arithmetically from the
// accept cycle and period; directed moves also carry hand-computed literals.
module tb_stepper_seq_ctrl;

  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stepper_en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_period = '0;
`ifdef STEPPER_HALFSTEP_EN
  logic        cmd_half = 1'b0;
`endif
  logic        cmd_ready;
  logic [3:0]  step_drive;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] pos_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  stepper_seq_ctrl #(.COUNT_W(16), .PERIOD_W(24), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .stepper_en (stepper_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
`ifdef STEPPER_HALFSTEP_EN
    .cmd_half   (cmd_half),
`endif
    .abort      (abort),
    .step_drive (step_drive),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .pos_count  (pos_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 coils off, 1 moving, 2 holding after a move.
  int          m_mode = 0, m_t0 = 0, m_per = 1, m_steps = 0, m_issued = 0, m_idx = 0, m_hold = 0;
  bit          m_dir = 0, m_ready = 0, m_done = 0, m_ab = 0;
  logic [15:0] m_pos = '0;
  bit          s_rst, s_en, s_valid, s_dir, s_abort;
  int          s_steps, s_period;
`ifdef STEPPER_HALFSTEP_EN
  bit          s_half, m_half;
`endif

  function automatic logic [3:0] model_drive(input int mode, input int idx);
    if (mode == 0) return 4'b0000;
`ifdef STEPPER_HALFSTEP_EN
    case (idx)
      0: return 4'b1001; 1: return 4'b0001; 2: return 4'b0011; 3: return 4'b0010;
      4: return 4'b0110; 5: return 4'b0100; 6: return 4'b1100; default: return 4'b1000;
    endcase
`else
    case (idx)
      0: return 4'b1001; 1: return 4'b0011; 2: return 4'b0110; default: return 4'b1100;
    endcase
`endif
  endfunction

  task automatic model_edge();
    m_done = 0;
    m_ab   = 0;
    if (s_rst) begin
      m_mode = 0; m_idx = 0; m_pos = '0; m_ready = 0;
    end else begin
      if (!s_en) begin
        m_mode = 0;
      end else if (m_mode != 1) begin
        if (s_valid && m_ready) begin
          m_mode = 1; m_t0 = cyc; m_per = (s_period == 0) ? 1 : s_period;
          m_steps = s_steps; m_issued = 0; m_dir = s_dir;
`ifdef STEPPER_HALFSTEP_EN
          m_half = s_half;
`endif
        end else if (m_mode == 2) begin
          m_hold--;
          if (m_hold == 0) m_mode = 0;
        end
      end else if ((cyc - m_t0 - 1) % m_per == 0) begin
        if (m_issued == m_steps || s_abort) begin
          m_done = 1; m_ab = (m_issued < m_steps); m_mode = 2; m_hold = HOLD;
        end else begin
`ifdef STEPPER_HALFSTEP_EN
          begin
            int amt;
            amt = (m_half || (m_idx % 2 == 1)) ? 1 : 2;
            m_idx = (m_idx + (m_dir ? amt : 8 - amt)) % 8;
          end
`else
          m_idx = (m_idx + (m_dir ? 1 : 3)) % 4;
`endif
          m_pos = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
          m_issued++;
        end
      end
      m_ready = s_en && (m_mode != 1) && !s_abort;
    end
  endtask

  // Sample inputs on the edge, advance the model, compare 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst; s_en = stepper_en; s_valid = cmd_valid; s_dir = cmd_dir;
      s_abort = abort; s_steps = int'(cmd_steps); s_period = int'(cmd_period);
`ifdef STEPPER_HALFSTEP_EN
      s_half = cmd_half;
`endif
      #1;
      cyc++;
      model_edge();
      chk("m_drive",   step_drive, model_drive(m_mode, m_idx));
      chk("m_busy",    busy,       m_mode == 1);
      chk("m_done",    done,       m_done);
      chk("m_aborted", aborted,    m_ab);
      chk("m_pos",     pos_count,  m_pos);
      chk("m_ready",   cmd_ready,  m_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus (driven on negedges) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_drive", step_drive, 4'b0000);
    chk("rst_pos", pos_count, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input bit dir, input int steps, input int period, input bit half, output int acc);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = 16'(steps); cmd_period = 24'(period);
`ifdef STEPPER_HALFSTEP_EN
    cmd_half = half;
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
    $display("cmd dir=%0d steps=%0d period=%0d half=%0d accepted at cycle %0d", dir, steps, period, half, acc);
  endtask

  task automatic wait_done(input int bound, output int dcyc);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    dcyc = cyc;
    $display("move done at cycle %0d pos=%0h aborted=%0d", cyc, pos_count, aborted);
  endtask

  initial begin
    int n0, d0;
    stepper_en = 1'b1;
    tick(2);

    // 1: forward 4 steps, period 10.
    do_reset();
    send_cmd(1, 4, 10, 0, n0);
    tick(1);  chk("t1_s1", step_drive, 4'b0011);
    tick(10); chk("t1_s2", step_drive, 4'b0110);
    tick(10); chk("t1_s3", step_drive, 4'b1100);
    tick(10); chk("t1_s4", step_drive, 4'b1001); chk("t1_busy", busy, 1'b1);
    tick(9);  chk("t1_nodone", done, 1'b0);
    tick(1);  chk("t1_done", done, 1'b1); chk("t1_ab", aborted, 1'b0);
    chk("t1_pos", pos_count, 16'd4);
    $display("move done at cycle %0d pos=%0h aborted=%0d", cyc, pos_count, aborted);

    // 2: reverse 3 steps, period 0, then hold expiry.
    do_reset();
    send_cmd(0, 3, 0, 0, n0);
    tick(1); chk("t2_s1", step_drive, 4'b1100);
    tick(1); chk("t2_s2", step_drive, 4'b0110);
    tick(1); chk("t2_s3", step_drive, 4'b0011);
    wait_done(10, d0);
    chk("t2_lat", 32'(d0 - n0), 32'd4);
    chk("t2_pos", pos_count, 16'hFFFD);
    tick(HOLD - 1); chk("t2_hold", step_drive, 4'b0011);
    tick(1);        chk("t2_off", step_drive, 4'b0000);

    // 3: zero-step move.
    do_reset();
    send_cmd(1, 0, 7, 0, n0);
    tick(1);
    chk("t3_done", done, 1'b1); chk("t3_ab", aborted, 1'b0);
    chk("t3_drive", step_drive, 4'b1001); chk("t3_pos", pos_count, 16'd0);
    chk("t3_ready", cmd_ready, 1'b1);

    // 4: abort after the third step.
    do_reset();
    send_cmd(1, 100, 5, 0, n0);
    tick(11); chk("t4_pos3", pos_count, 16'd3);
    abort = 1'b1;
    tick(4);  chk("t4_nodone", done, 1'b0);
    tick(1);
    chk("t4_done", done, 1'b1); chk("t4_ab", aborted, 1'b1);
    chk("t4_pos", pos_count, 16'd3); chk("t4_busy", busy, 1'b0);
    chk("t4_hold", step_drive, 4'b1100);
    abort = 1'b0;
    $display("move done at cycle %0d pos=%0h aborted=%0d", cyc, pos_count, aborted);

    // 5: accept in HOLD without de-energizing, then drop enable mid-move.
    send_cmd(1, 2, 3, 0, n0);
    chk("t5_keep", step_drive, 4'b1100);
    tick(1); chk("t5_s1", step_drive, 4'b1001);
    wait_done(20, d0);
    chk("t5_pos", pos_count, 16'd5);
    send_cmd(0, 50, 2, 0, n0);
    tick(4); chk("t5_pos2", pos_count, 16'd3);
    stepper_en = 1'b0;
    tick(1);
    chk("t5_off", step_drive, 4'b0000); chk("t5_nobusy", busy, 1'b0); chk("t5_nodone", done, 1'b0);
    tick(5);
    chk("t5_held", pos_count, 16'd3); chk("t5_ready", cmd_ready, 1'b0);
    $display("enable dropped at cycle %0d pos=%0h", cyc, pos_count);
    stepper_en = 1'b1;
    tick(2);

`ifdef STEPPER_HALFSTEP_EN
    // 6: half-step forward 3, then full-step forward 2 from odd index.
    do_reset();
    send_cmd(1, 3, 2, 1, n0);
    tick(1); chk("t6_h1", step_drive, 4'b0001);
    tick(2); chk("t6_h2", step_drive, 4'b0011);
    tick(2); chk("t6_h3", step_drive, 4'b0010);
    wait_done(10, d0);
    send_cmd(1, 2, 1, 0, n0);
    tick(1); chk("t6_f1", step_drive, 4'b0110);
    tick(1); chk("t6_f2", step_drive, 4'b1100);
    wait_done(10, d0);
    chk("t6_pos", pos_count, 16'd5);
`endif

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
